// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the fetch/decode pipeline register: widths, opcodes,
// FSM state encodings and the packet layout handed to decode.
package if_id_buffer_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;

  localparam logic [3:0]         ITYPE_OPC = 4'd8;
  localparam logic [INSTR_W-1:0] NOP       = 16'd0;

  typedef enum logic {
    NORMAL   = 1'b0,
    IMM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] imm;
    logic               intr;
    logic               itype;
    logic               valid;
  } packet_t;

  localparam packet_t BUBBLE = '0;

  function automatic logic is_itype(input logic [INSTR_W-1:0] instr);
    return instr[15:12] == ITYPE_OPC;
  endfunction

endpackage

// File: rtl/if_id_pair_fsm.sv
// Pairs I-type opcodes with the immediate word fetched one cycle later and
// selects the packet that the output register captures on the next edge.
module if_id_pair_fsm
  import if_id_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               INT_in,
  input  logic [PC_W-1:0]    PC_IF_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] Data_in,
  output packet_t            pkt_nxt
);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] pend_instr, pend_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      pend_instr <= NOP;
    end else if (flush) begin
      state      <= NORMAL;
      pend_instr <= NOP;
    end else if (!stall) begin
      state      <= state_nxt;
      pend_instr <= pend_nxt;
    end
  end

  // An interrupt always returns to NORMAL and drops any half-formed pair.
  always_comb begin
    state_nxt = NORMAL;
    pend_nxt  = NOP;
    if (state == NORMAL && !INT_in && is_itype(instr_in)) begin
      state_nxt = IMM_WAIT;
      pend_nxt  = instr_in;
    end
  end

  always_comb begin
    pkt_nxt = BUBBLE;
    if (INT_in) begin
      pkt_nxt.pc    = PC_IF_in;
      pkt_nxt.intr  = 1'b1;
      pkt_nxt.valid = 1'b1;
    end else if (state == IMM_WAIT) begin
      pkt_nxt.pc    = PC_IF_in;
      pkt_nxt.instr = pend_instr;
      pkt_nxt.imm   = Data_in;
      pkt_nxt.itype = 1'b1;
      pkt_nxt.valid = 1'b1;
    end else if (!is_itype(instr_in)) begin
      pkt_nxt.pc    = PC_IF_in;
      pkt_nxt.instr = instr_in;
      pkt_nxt.valid = instr_in != NOP;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register with I-type immediate pairing, stall and flush.
// Optional IF_ID_PERF_EN macro adds saturating bubble and flush counters.
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    PC_IF_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] Data_in,
  input  logic               INT_in,
  input  logic               stall,
  input  logic               flush,
`ifdef IF_ID_PERF_EN
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        flush_cnt,
`endif
  output logic [PC_W-1:0]    PC_ID_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] Imm_out,
  output logic               INT_out,
  output logic               is_Itype_out,
  output logic               valid_out
);

  packet_t pkt_nxt, pkt_p0;

  if_id_pair_fsm u_pair_fsm (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .INT_in   (INT_in),
    .PC_IF_in (PC_IF_in),
    .instr_in (instr_in),
    .Data_in  (Data_in),
    .pkt_nxt  (pkt_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pkt_p0 <= BUBBLE;
    else if (flush)  pkt_p0 <= BUBBLE;
    else if (!stall) pkt_p0 <= pkt_nxt;
  end

  assign PC_ID_out    = pkt_p0.pc;
  assign instr_out    = pkt_p0.instr;
  assign Imm_out      = pkt_p0.imm;
  assign INT_out      = pkt_p0.intr;
  assign is_Itype_out = pkt_p0.itype;
  assign valid_out    = pkt_p0.valid;

`ifdef IF_ID_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A flush always lands a bubble, even when it overrides a stall.
  logic bubble_evt;
  assign bubble_evt = flush || (!stall && !pkt_nxt.valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= 16'd0;
      flush_cnt  <= 16'd0;
    end else begin
      if (bubble_evt) bubble_cnt <= sat_inc(bubble_cnt);
      if (flush)      flush_cnt  <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Pipeline register between the fetch stage and decode. It captures the fetch outputs: PC+1, instruction word, raw memory word and the interrupt bit. It pairs each I-type opcode with the immediate word fetched in the following cycle, so decode always sees one complete instruction packet. Upstream stall holds the packet; flush squashes it.

Parameters:
PC_W, 32, width of PC value
INSTR_W, 16, width of instruction and immediate words
ITYPE_OPC, 4'd8, opcode (instr[15:12]) marking an I-type instruction

Ports:
clk  in  1  CPU clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
PC_IF_in  in  PC_W  PC+1 from fetch
instr_in  in  INSTR_W  fetched instruction (NOP = 0 when fetch inserts a bubble)
Data_in  in  INSTR_W  raw memory word from fetch (immediate source)
INT_in  in  1  interrupt bit from fetch
stall  in  1  hold all state and outputs
flush  in  1  squash: jump, pop PC or exception
PC_ID_out  out  PC_W  packet PC
instr_out  out  INSTR_W  packet instruction
Imm_out  out  INSTR_W  packet immediate (0 if not I-type)
INT_out  out  1  packet is interrupt entry
is_Itype_out  out  1  packet carries a valid immediate
valid_out  out  1  packet is a real instruction or interrupt

Behaviour:
- Reset (reset=0, async): every output = 0, state = NORMAL, pending regs = 0. The first valid packet can appear on the first rising edge after reset deasserts.
- Priority per edge: reset > flush > stall > normal operation.
- States: NORMAL and IMM_WAIT.
- NORMAL, INT_in=1: emit the packet {PC_IF_in, instr=0, Imm=0, INT=1, is_Itype=0, valid=1}. Stay in NORMAL.
- NORMAL, instr_in[15:12]==ITYPE_OPC: latch instr_in into pend_instr. Emit a bubble (valid=0, instr=0, INT=0, is_Itype=0, Imm=0). Go to IMM_WAIT.
- NORMAL, other opcodes: emit {PC_IF_in, instr_in, Imm=0, INT=0, is_Itype=0, valid=(instr_in!=0)}.
- IMM_WAIT, INT_in=0: emit {PC_IF_in, pend_instr, Imm=Data_in, INT=0, is_Itype=1, valid=1}. Go to NORMAL.
  - Packet PC is the PC sampled in the immediate cycle, i.e. the address after the immediate. This is the return address for calls.
- IMM_WAIT, INT_in=1: discard pend_instr and emit the INT packet, because fetch restarts its pairing on interrupt. Go to NORMAL.
- Latency: 1 cycle for normal and INT packets. 2 cycles from opcode fetch for I-type packets, with exactly one bubble before the packet.
- stall=1: outputs, state and pend_instr hold. Inputs are ignored.
- flush=1: outputs go to the bubble encoding, state = NORMAL, pend_instr = 0. This applies even if stall=1 on the same edge.
- flush=1 with INT_in=1 on the same edge: flush wins and the packet is squashed. Fetch re-presents INT after the redirect.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
Macro IF_ID_PERF_EN.
- Defined: adds outputs bubble_cnt[15:0] and flush_cnt[15:0].
  - bubble_cnt increments on each non-stalled edge where valid_out becomes 0.
  - flush_cnt increments on each edge with flush=1.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds: ITYPE_OPC, NOP encoding (16'd0), state encodings NORMAL=1'b0 and IMM_WAIT=1'b1, and the widths PC_W/INSTR_W.
- One sub-module, if_id_pair_fsm: state register, pend_instr, and next-state/packet-select logic.
- The top level holds the output registers and the optional counters.

Test Plan:
- Reset mid-run: drive reset=0 asynchronously between edges -> all outputs 0 immediately. After release, instr_in=16'h1234, PC_IF_in=5 -> next edge valid=1, instr_out=16'h1234, PC_ID_out=5, Imm_out=0.
- I-type pairing: instr_in=16'h8A00 (PC 10), next cycle instr_in=0, Data_in=16'h00FF (PC 11) -> bubble, then instr_out=16'h8A00, Imm_out=16'h00FF, is_Itype=1, PC_ID_out=11.
- Stall in IMM_WAIT: after 16'h8A00, hold stall=1 for 3 cycles with Data_in changing, then release with Data_in=16'h0042 -> outputs frozen during stall, then Imm_out=16'h0042.
- Flush in IMM_WAIT: after 16'h8A00, assert flush with stall=1 -> bubble output and state NORMAL. Next instr_in=16'h2001 -> emitted as a normal packet with is_Itype=0.
- Interrupt: INT_in=1 while in IMM_WAIT -> INT_out=1, valid=1, instr_out=0, pending 16'h8A00 never emitted. INT_in=1 with flush=1 on the same edge -> bubble.
- IF_ID_PERF_EN: apply 3 flushes and 2 I-type pairs -> flush_cnt=3, bubble_cnt=5. Preload near saturation -> count holds at 16'hFFFF.
